stream_demux_1xn: RTL and testbench
===================================

// Module: stream_demux_1xn
// PURPOSE
//  - Registered 1-to-N stream demultiplexer with valid/ready handshake on the input and every output.
//  - Routes one input word per accepted beat to the channel chosen by in_sel, or to all channels in broadcast mode.
//  - Counts words dropped for out-of-range selects.
//  - Parametrised, clocked successor of the combinational 1x2/1x4/1x8 demuxes.
//  - Sits between a single producer and N independent consumers.
// PARAMETERS
//  - N_CH     4  number of output channels, >= 2
//  - DATA_W   8  data width per word, >= 1
//  - SEL_W    $clog2(N_CH)+1  select width; the extra bit allows out-of-range codes
//  - CNT_W    8  drop counter width
// PORTS
//  - clk        in   1             rising-edge clock, the only clock
//  - rst_n      in   1             asynchronous, active-low reset
//  - in_valid   in   1             input word present
//  - in_ready   out  1             block can accept the input word (combinational)
//  - in_data    in   DATA_W        input word
//  - in_sel     in   SEL_W         target channel; ignored when in_bcast=1
//  - in_bcast   in   1             copy the word to all N_CH channels
//  - out_valid  out  N_CH          per-channel valid (registered)
//  - out_ready  in   N_CH          per-channel consumer ready
//  - out_data   out  N_CH*DATA_W   channel k occupies bits [k*DATA_W +: DATA_W] (registered)
//  - drop_cnt   out  CNT_W         saturating count of dropped words
//  - Clocking and reset: one clock; reset is asynchronous and active-low.
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, drop_cnt=0. Reset may assert mid-transfer: pending words are discarded, with no partial state.
//  - Storage: each channel has a one-entry holding register.
//    - free[k] = !out_valid[k] || out_ready[k].
//    - Full throughput: a pop and a load on the same channel in one cycle is allowed.
//  - in_ready, combinational, no dependence on in_valid:
//    - in_bcast=1: in_ready = AND of all free[k].
//    - in_bcast=0 and in_sel<N_CH: in_ready = free[in_sel].
//    - in_bcast=0 and in_sel>=N_CH: in_ready = 1, because the word is dropped.
//  - Accept: acc = in_valid && in_ready. Latency is 1 cycle: the word is visible on out_data/out_valid at the next edge.
//  - Channel k update, in priority order:
//    1. Load: if acc and (in_bcast or in_sel==k), then data_k <= in_data and out_valid[k] <= 1.
//    2. Pop: else if out_valid[k] && out_ready[k], then out_valid[k] <= 0 and data_k is held.
//    3. Hold: otherwise hold.
//  - Stability: while out_valid[k] && !out_ready[k], data_k and out_valid[k] do not change.
//  - Broadcast is all-or-nothing. A word is never delivered to only a subset of channels.
//  - Drop: if acc && !in_bcast && in_sel>=N_CH, then drop_cnt <= drop_cnt+1, saturating at 2^CNT_W-1. No channel changes.
//  - Ordering: words to the same channel leave in acceptance order. Channels are mutually independent.
//  - No state machine beyond per-channel full/empty. in_data is sampled only on acc.
// STRUCTURE
//  - Package stream_demux_pkg holds:
//    - function chan_free(valid, ready);
//    - localparam SEL_W derivation helper;
//    - typedef of the channel data word.
//  - Sub-module demux_chan_reg, one instance per channel via generate:
//    - ports: clk, rst_n, load, d, valid, ready, q;
//    - owns the load/pop/hold rule and the reset values.
//  - The top level holds the in_ready decode, select/broadcast fan-out and the drop counter.
// TESTING (N_CH=4, DATA_W=8, CNT_W=4)
//  1. Routing:
//     - stimulus: send 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3, all out_ready=1;
//     - required: each value appears on its own channel exactly 1 cycle after acceptance, and no other out_valid rises.
//  2. Backpressure:
//     - stimulus: out_ready[2]=0, send 0xA5 then 0x5A to sel2;
//     - required: 0xA5 is held stable and in_ready=0 for sel2;
//     - required: a sel1 word is still accepted in parallel;
//     - required: when ready[2] rises, 0x5A loads on the same edge that 0xA5 pops.
//  3. Broadcast:
//     - stimulus: out_valid[3]=1 with ready[3]=0, bcast word 0xC3;
//     - required: in_ready=0 and no channel loads;
//     - required: after ready[3]=1, all four channels show 0xC3 on the same cycle.
//  4. Drop and saturation:
//     - stimulus: 20 words with sel=5;
//     - required: in_ready=1 throughout, no out_valid rises, drop_cnt reaches 15 and holds there.
//  5. Streaming:
//     - stimulus: continuous valid to sel0 with out_ready[0]=1;
//     - required: one word per cycle, in order, with no bubbles.
//  6. Reset mid-operation:
//     - stimulus: assert rst_n=0 asynchronously while 2 channels are full;
//     - required: out_valid=0, out_data=0 and drop_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

  localparam int DATA_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] chan_word_t;

  // One extra select bit so out-of-range codes are representable and can be dropped.
  function automatic int sel_width(input int n_ch);
    return $clog2(n_ch) + 1;
  endfunction

  function automatic logic chan_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single demux output channel.
module demux_chan_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] q
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load wins over pop so a pop and a reload can share one edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux with per-channel holding registers,
// broadcast mode and a saturating counter of words dropped for bad selects.
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_width(N_CH),
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [SEL_W-1:0] N_CH_SEL = SEL_W'(N_CH);

  logic [N_CH-1:0]  free;
  logic [N_CH-1:0]  load;
  logic             sel_ok;
  logic             sel_free;
  logic             acc;
  logic             drop;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sel_ok   = in_sel < N_CH_SEL;
    sel_free = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      free[k] = chan_free(out_valid[k], out_ready[k]);
      if (in_sel == SEL_W'(k)) sel_free = free[k];
    end

    // Broadcast needs every channel free so a word never lands on a subset.
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = sel_free;
    else             in_ready = 1'b1;

    acc = in_valid && in_ready;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = acc && (in_bcast || (in_sel == SEL_W'(k)));
    end

    drop       = acc && !in_bcast && !sel_ok;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    demux_chan_reg #(.DATA_W(DATA_W)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .d     (in_data),
      .valid (out_valid[k]),
      .ready (out_ready[k]),
      .q     (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural channel model.
module tb_stream_demux_1xn;
  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data = '0;
  logic [SEL_W-1:0]       in_sel = '0;
  logic                   in_bcast = 1'b0;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready = '1;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]       drop_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  stream_demux_1xn #(.N_CH(N_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: each channel is "holding a word or not"; drops count up to a ceiling.
  bit       m_v [N_CH];
  int       m_d [N_CH];
  int       m_drop;

  function automatic bit model_ready();
    bit r;
    if (in_bcast) begin
      r = 1'b1;
      for (int k = 0; k < N_CH; k++) if (m_v[k] && !out_ready[k]) r = 1'b0;
    end else if (int'(in_sel) < N_CH) begin
      r = !m_v[int'(in_sel)] || out_ready[int'(in_sel)];
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        m_v[k] <= 1'b0;
        m_d[k] <= 0;
      end
      m_drop <= 0;
    end else begin
      bit acc;
      acc = in_valid && model_ready();
      for (int k = 0; k < N_CH; k++) begin
        if (acc && (in_bcast || int'(in_sel) == k)) begin
          m_v[k] <= 1'b1;
          m_d[k] <= int'(in_data);
        end else if (m_v[k] && out_ready[k]) begin
          m_v[k] <= 1'b0;
        end
      end
      if (acc && !in_bcast && int'(in_sel) >= N_CH && m_drop < CNT_MAX) m_drop <= m_drop + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("mdl_in_ready", int'(in_ready), int'(model_ready()));
      check("mdl_drop_cnt", int'(drop_cnt), m_drop);
      for (int k = 0; k < N_CH; k++) begin
        check("mdl_out_valid", int'(out_valid[k]), int'(m_v[k]));
        check("mdl_out_data", int'(out_data[k*DATA_W +: DATA_W]), m_d[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int sel, input bit bc, input int dat);
    in_valid = v;
    in_sel   = SEL_W'(sel);
    in_bcast = bc;
    in_data  = DATA_W'(dat);
    #1;
  endtask

  function automatic int ch(input int k);
    return int'(out_data[k*DATA_W +: DATA_W]);
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    chk_en = 1'b1;

    // Routing
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, 1'b0, 8'h11 * (i + 1));
      check("route_in_ready", int'(in_ready), 1);
      tick();
      check("route_onehot", int'(out_valid), 1 << i);
      check("route_data", ch(i), 8'h11 * (i + 1));
    end
    drive(1'b0, 0, 1'b0, 0);
    tick();
    check("route_drain", int'(out_valid), 0);

    // Backpressure on channel 2
    out_ready = 4'b1011;
    drive(1'b1, 2, 1'b0, 8'hA5);
    tick();
    check("bp_first_load", ch(2), 8'hA5);
    drive(1'b1, 2, 1'b0, 8'h5A);
    check("bp_in_ready_blocked", int'(in_ready), 0);
    tick();
    check("bp_held_data", ch(2), 8'hA5);
    check("bp_held_valid", int'(out_valid), 4'b0100);
    drive(1'b1, 1, 1'b0, 8'h77);
    check("bp_parallel_ready", int'(in_ready), 1);
    tick();
    check("bp_parallel_valid", int'(out_valid), 4'b0110);
    check("bp_parallel_data", ch(1), 8'h77);
    check("bp_still_held", ch(2), 8'hA5);
    out_ready = 4'b1111;
    drive(1'b1, 2, 1'b0, 8'h5A);
    check("bp_release_ready", int'(in_ready), 1);
    tick();
    check("bp_swap_data", ch(2), 8'h5A);
    check("bp_swap_valid", int'(out_valid), 4'b0100);
    drive(1'b0, 0, 1'b0, 0);
    tick();

    // Broadcast blocked by a full channel 3
    out_ready = 4'b0111;
    drive(1'b1, 3, 1'b0, 8'h99);
    tick();
    drive(1'b1, 0, 1'b1, 8'hC3);
    check("bc_blocked_ready", int'(in_ready), 0);
    tick();
    check("bc_no_load_valid", int'(out_valid), 4'b1000);
    check("bc_no_load_data", ch(3), 8'h99);
    out_ready = 4'b1111;
    #1;
    check("bc_open_ready", int'(in_ready), 1);
    tick();
    check("bc_all_valid", int'(out_valid), 4'b1111);
    for (int k = 0; k < N_CH; k++) check("bc_all_data", ch(k), 8'hC3);
    drive(1'b0, 0, 1'b0, 0);
    tick();

    // Drop and saturation
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5, 1'b0, i);
      check("drop_in_ready", int'(in_ready), 1);
      tick();
      check("drop_no_valid", int'(out_valid), 0);
      check("drop_cnt", int'(drop_cnt), (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
    end

    // Streaming into channel 0
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 0, 1'b0, 8'h40 + i);
      check("stream_ready", int'(in_ready), 1);
      tick();
      check("stream_valid", int'(out_valid[0]), 1);
      check("stream_data", ch(0), 8'h40 + i);
    end

    // Reset asserted between edges with two channels full
    out_ready = 4'b0000;
    drive(1'b1, 1, 1'b0, 8'hE1);
    tick();
    drive(1'b0, 0, 1'b0, 0);
    tick();
    check("pre_rst_valid", int'(out_valid), 4'b0011);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_data", int'(out_data), 0);
    check("arst_drop_cnt", int'(drop_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_sel    = SEL_W'($urandom_range(0, 7));
      in_bcast  = 1'($urandom_range(0, 7) == 0);
      in_data   = DATA_W'($urandom);
      out_ready = N_CH'($urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
